twos_word_loader: RTL and testbench
===================================

// Module: twos_word_loader
// PURPOSE
//   Upstream feeder for the 4-bit two's-complement stage (two_com).
//   - Assembles a serial bit stream, LSB first, into a WIDTH-bit word.
//   - Holds the word stable on m_word, which drives two_com.I directly.
//   - Completion uses a valid/ready handshake; the word stays put until the consumer takes it.
//   - Flags the most-negative input (1000), whose negation overflows.
// PARAMETERS
//   WIDTH   4   word width in bits; must be >= 2
// PORTS
//   clk        in   1      single clock, rising-edge
//   rst_n      in   1      reset, asynchronous, active-low
//   s_start    in   1      one-cycle pulse: begin a new frame (no bit carried this cycle)
//   s_bit      in   1      serial data bit, LSB first
//   s_bit_vld  in   1      s_bit is valid this cycle
//   m_word     out  WIDTH  assembled word, feeds two_com.I
//   m_valid    out  1      m_word is complete and stable
//   m_ready    in   1      consumer accepts m_word
//   m_min_neg  out  1      m_word == {1'b1,{WIDTH-1{1'b0}}}; valid only while m_valid
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state=IDLE, m_word=0, m_valid=0, m_min_neg=0, bit count=0.
//   States: IDLE, SHIFT, HOLD.
//   IDLE:
//     - s_start -> SHIFT with count=0 and m_word cleared to 0.
//     - s_bit_vld with no active frame is ignored.
//   SHIFT:
//     - Each s_bit_vld writes s_bit into m_word[count], then count++.
//     - When the bit at count==WIDTH-1 is written: go to HOLD, m_valid=1 and
//       m_min_neg updated on the same edge.
//     - So m_valid asserts the cycle after the last bit is sampled.
//     - s_bit_vld low: no change; gaps of any length are allowed.
//     - s_start in SHIFT aborts the frame: count=0, m_word=0, stay in SHIFT.
//       Any s_bit_vld in that same cycle is ignored.
//   HOLD:
//     - m_word, m_valid and m_min_neg are stable until m_valid && m_ready.
//     - s_bit_vld is ignored; no bits are lost into a held word.
//     - Accept alone (m_valid && m_ready): m_valid=0, go to IDLE.
//       m_word keeps its last value.
//     - Accept with s_start in the same cycle: go to SHIFT, count=0, m_word=0,
//       m_valid=0. Back-to-back frames are legal.
//     - s_start without accept is ignored.
//   m_ready while m_valid=0 has no effect.
//   Counter: $clog2(WIDTH) bits. It never wraps; the exit to HOLD happens at WIDTH-1.
//   Reset mid-frame: outputs go to reset values immediately; the partial word is discarded.
//   Throughput: one word per WIDTH+1 cycles at best (start cycle + WIDTH bits).
// STRUCTURE
//   Package twos_pkg:
//     - typedef enum logic [1:0] {IDLE, SHIFT, HOLD} loader_state_t
//     - localparam int TWOS_WIDTH = 4
//   Implementation:
//     - No sub-module inside the loader.
//     - Single registered FSM with counter and shift register.
//     - Combinational compare for the min-neg flag, registered as m_min_neg.
//   The bench instantiates two_com on m_word and checks its output O.
// TESTING
//   1. Frame: start, then bits 1,0,1,0.
//      -> m_word=0101 one cycle after the 4th bit, m_valid=1, m_min_neg=0;
//         two_com.O=1011.
//   2. Frame: bits 0,0,0,1 (word 1000).
//      -> m_word=1000, m_min_neg=1; two_com.O=1000 (overflow case).
//   3. Backpressure: word 0111 with m_ready=0 for 5 cycles while extra bits and starts are driven.
//      -> m_word stays 0111 and m_valid stays 1; on m_ready=1, m_valid=0 next cycle.
//   4. Abort: start, bits 1,1, then start again, then bits 0,1,1,1.
//      -> m_word=1110, two_com.O=0010.
//   5. Back-to-back: accept and s_start in the same cycle, then bits 1,0,0,1.
//      -> no idle gap, second m_word=1001, two_com.O=0111.
//   6. Reset: rst_n low after 2 bits of a frame.
//      -> m_valid=0 and m_word=0 immediately; a later full frame 0001 gives m_word=0001.

Source files
------------

// File: rtl/twos_pkg.sv
// Shared types and widths for the two's-complement loader slice.
package twos_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } loader_state_t;

   localparam int TWOS_WIDTH = 4;

endpackage

// File: rtl/two_com.sv
// Combinational two's-complement negation stage fed by the loader.
module two_com #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] I,
   output logic [WIDTH-1:0] O
);

   assign O = ~I + WIDTH'(1);

endmodule

// File: rtl/twos_word_loader.sv
// Serial LSB-first word assembler with valid/ready hold and a most-negative flag.
module twos_word_loader
   import twos_pkg::*;
#(
   parameter int unsigned WIDTH = TWOS_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_start,
   input  logic             s_bit,
   input  logic             s_bit_vld,
   output logic [WIDTH-1:0] m_word,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_min_neg
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   loader_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             min_neg_q, min_neg_d;

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         word_q    <= '0;
         valid_q   <= 1'b0;
         min_neg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         min_neg_q <= min_neg_d;
      end
   end

   // Next-state logic; a start always wins over a bit arriving in the same cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      valid_d   = valid_q;
      min_neg_d = min_neg_q;
      unique case (state_q)
         IDLE: begin
            if (s_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               word_d  = '0;
            end
         end
         SHIFT: begin
            if (s_start) begin
               cnt_d  = '0;
               word_d = '0;
            end else if (s_bit_vld) begin
               word_d[cnt_q] = s_bit;
               if (cnt_q == LAST_IDX) begin
                  state_d   = HOLD;
                  valid_d   = 1'b1;
                  min_neg_d = (word_d == MIN_NEG);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (m_ready) begin
               valid_d   = 1'b0;
               min_neg_d = 1'b0;
               if (s_start) begin
                  state_d = SHIFT;
                  cnt_d   = '0;
                  word_d  = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign m_word    = word_q;
   assign m_valid   = valid_q;
   assign m_min_neg = min_neg_q;

endmodule

// File: tb/tb_twos_word_loader.sv
// Bench for twos_word_loader driving the two_com stage from m_word.
module tb_twos_word_loader;
   import twos_pkg::*;

   localparam int unsigned W = TWOS_WIDTH;

   logic         clk;
   logic         rst_n;
   logic         s_start;
   logic         s_bit;
   logic         s_bit_vld;
   logic [W-1:0] m_word;
   logic         m_valid;
   logic         m_ready;
   logic         m_min_neg;
   logic [W-1:0] o_neg;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] word;
      logic         min_neg;
      logic [W-1:0] o;
   } exp_t;

   exp_t sb[$];

   twos_word_loader #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_start   (s_start),
      .s_bit     (s_bit),
      .s_bit_vld (s_bit_vld),
      .m_word    (m_word),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_min_neg (m_min_neg)
   );

   two_com #(.WIDTH(W)) u_neg (
      .I (m_word),
      .O (o_neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_frame();
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input bit gaps);
      for (int i = 0; i < int'(W); i++) begin
         s_bit_vld = 1'b1;
         s_bit     = w[i];
         tick();
         s_bit_vld = 1'b0;
         if (gaps && i < int'(W) - 1) tick();
      end
   endtask

   // Pops the next expectation once m_valid shows up; m_valid must be there right after the last bit.
   task automatic collect(input string name);
      int   n;
      exp_t e;
      n = 0;
      while (!m_valid && n < 8) begin
         tick();
         n++;
      end
      chk({name, "_latency"}, 32'(n), 32'd0);
      chk({name, "_valid"}, 32'(m_valid), 32'd1);
      if (sb.size() == 0) begin
         chk({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({name, "_word"}, 32'(m_word), 32'(e.word));
         chk({name, "_min_neg"}, 32'(m_min_neg), 32'(e.min_neg));
         chk({name, "_two_com"}, 32'(o_neg), 32'(e.o));
      end
   endtask

   task automatic accept(input string name);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk({name, "_accept_valid"}, 32'(m_valid), 32'd0);
   endtask

   exp_t vec[6];

   initial begin
      vec[0] = '{word: 4'b0101, min_neg: 1'b0, o: 4'b1011};
      vec[1] = '{word: 4'b1000, min_neg: 1'b1, o: 4'b1000};
      vec[2] = '{word: 4'b0000, min_neg: 1'b0, o: 4'b0000};
      vec[3] = '{word: 4'b1111, min_neg: 1'b0, o: 4'b0001};
      vec[4] = '{word: 4'b0011, min_neg: 1'b0, o: 4'b1101};
      vec[5] = '{word: 4'b0110, min_neg: 1'b0, o: 4'b1010};

      rst_n = 1'b0; s_start = 1'b0; s_bit = 1'b0; s_bit_vld = 1'b0; m_ready = 1'b0;
      tick(); tick();
      chk("rst_word", 32'(m_word), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_min_neg", 32'(m_min_neg), 32'd0);
      rst_n = 1'b1;
      tick();

      // Bits and ready in IDLE must not disturb anything.
      s_bit_vld = 1'b1; s_bit = 1'b1; m_ready = 1'b1;
      tick(); tick();
      s_bit_vld = 1'b0; m_ready = 1'b0;
      chk("idle_ignore_word", 32'(m_word), 32'd0);
      chk("idle_ignore_valid", 32'(m_valid), 32'd0);

      for (int i = 0; i < 6; i++) begin
         start_frame();
         sb.push_back(vec[i]);
         send_bits(vec[i].word, (i % 2) == 1);
         collect($sformatf("vec%0d", i));
         accept($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_keep_word", i), 32'(m_word), 32'(vec[i].word));
      end

      // Backpressure with stray bits and starts.
      start_frame();
      sb.push_back('{word: 4'b0111, min_neg: 1'b0, o: 4'b1001});
      send_bits(4'b0111, 1'b0);
      collect("bp");
      for (int k = 0; k < 5; k++) begin
         s_start   = k[0];
         s_bit_vld = 1'b1;
         s_bit     = 1'($urandom_range(1, 0));
         tick();
         chk($sformatf("bp_hold_word%0d", k), 32'(m_word), 32'h7);
         chk($sformatf("bp_hold_valid%0d", k), 32'(m_valid), 32'd1);
      end
      s_start = 1'b0; s_bit_vld = 1'b0;
      accept("bp");

      // Abort: restart after two bits, with a bit offered in the restart cycle.
      start_frame();
      s_bit_vld = 1'b1; s_bit = 1'b1;
      tick(); tick();
      s_start = 1'b1;
      tick();
      s_start = 1'b0; s_bit_vld = 1'b0;
      sb.push_back('{word: 4'b1110, min_neg: 1'b0, o: 4'b0010});
      send_bits(4'b1110, 1'b0);
      collect("abort");

      // Back-to-back: accept and start together, bits follow with no idle cycle.
      m_ready = 1'b1; s_start = 1'b1;
      tick();
      m_ready = 1'b0; s_start = 1'b0;
      chk("b2b_valid_drop", 32'(m_valid), 32'd0);
      chk("b2b_word_clear", 32'(m_word), 32'd0);
      sb.push_back('{word: 4'b1001, min_neg: 1'b0, o: 4'b0111});
      send_bits(4'b1001, 1'b0);
      collect("b2b");
      accept("b2b");

      // Asynchronous reset in the middle of a frame.
      start_frame();
      s_bit_vld = 1'b1; s_bit = 1'b1;
      tick(); tick();
      s_bit_vld = 1'b0;
      chk("mid_partial_word", 32'(m_word), 32'h3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_word", 32'(m_word), 32'd0);
      chk("mid_rst_valid", 32'(m_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      start_frame();
      sb.push_back('{word: 4'b0001, min_neg: 1'b0, o: 4'b1111});
      send_bits(4'b0001, 1'b0);
      collect("post_rst");
      accept("post_rst");

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
